// File: rtl/tri_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tri_bus_ctrl
// Description : Controller for a shared tri-state bus. It accepts write words
//               and drives them onto the bus for one cycle each, then releases
//               the bus for TURNAROUND idle cycles. It also accepts read
//               requests and samples the bus one cycle after the handshake.
//
// Parameters  : WIDTH      - bus and data width in bits (>= 1)
//               TURNAROUND - Z cycles after a drive before the next operation
//                            (0..15)
// Macro       : TRI_BUS_CTRL_BURST_EN - when defined, a write may be accepted
//               while a word is on the bus, giving back-to-back bus words with
//               the turnaround only after the last one.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               wr_valid/wr_ready - write handshake, wr_data = word to drive
//               rd_req/rd_ready   - read-request handshake
//               rd_valid          - one-cycle pulse, rd_data holds the sample
//               bus               - shared tri-state bus (Z when not driving)
//               bus_oe            - high exactly while this block drives bus
//
// Revision    : 1.0 - initial release
// ============================================================================
module tri_bus_ctrl #(
    parameter int WIDTH      = 32,
    parameter int TURNAROUND = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    inout  wire  [WIDTH-1:0] bus,
    output logic             bus_oe
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_TURN   = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    // The counter is loaded with TURNAROUND-1 so that it expires after exactly
    // TURNAROUND cycles in TURN; with no turnaround TURN is skipped entirely.
    localparam logic [3:0] c_turn_load = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic       c_has_turn  = (TURNAROUND > 0);

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_rd_valid;
    logic               w_wr_hs;
    logic               w_rd_hs;

    // Ready outputs are gated with rst so nothing is accepted in a reset cycle.
`ifdef TRI_BUS_CTRL_BURST_EN
    assign wr_ready = !rst && ((r_state == ST_IDLE) || (r_state == ST_DRIVE));
`else
    assign wr_ready = !rst && (r_state == ST_IDLE);
`endif
    // A write wins over a simultaneous read.
    assign rd_ready = !rst && (r_state == ST_IDLE) && !wr_valid;

    assign w_wr_hs  = wr_valid && wr_ready;
    assign w_rd_hs  = rd_req && rd_ready;

    assign bus_oe   = (r_state == ST_DRIVE);
    assign bus      = bus_oe ? r_out : {WIDTH{1'bz}};
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_hs) begin
                    w_next = ST_DRIVE;
                end else if (w_rd_hs) begin
                    w_next = ST_SAMPLE;
                end
            end
            ST_DRIVE: begin
`ifdef TRI_BUS_CTRL_BURST_EN
                if (w_wr_hs) begin
                    w_next = ST_DRIVE;
                end else
`endif
                if (c_has_turn) begin
                    w_next = ST_TURN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_out      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_hs) begin
                r_out <= wr_data;
            end

            // Reloading on every DRIVE cycle means the last word of a burst
            // always starts a full turnaround.
            if (r_state == ST_DRIVE) begin
                r_cnt <= c_turn_load;
            end else if ((r_state == ST_TURN) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (r_state == ST_SAMPLE) begin
                r_rd_data <= bus;
            end
            r_rd_valid <= (r_state == ST_SAMPLE);
        end
    end

endmodule
`default_nettype wire
